// File: rtl/viterbi_ber_checker.sv
// Receive-side BER monitor: hunts for the tx->rx latency (in tx pushes), locks to it,
// then counts compared bits and residual errors, dropping lock on a bad window.
module viterbi_ber_checker #(
    parameter int MAX_LAT    = 64,
    parameter int LOCK_LEN   = 32,
    parameter int WIN        = 64,
    parameter int UNLOCK_ERR = 8,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tx_valid_i,
    input  logic                       tx_bit_i,
    input  logic                       rx_valid_i,
    input  logic                       rx_bit_i,
    input  logic                       clear_i,
    output logic                       locked_o,
    output logic [$clog2(MAX_LAT)-1:0] latency_o,
    output logic [CNT_W-1:0]           bit_ct_o,
    output logic [CNT_W-1:0]           err_ct_o,
    output logic                       lock_loss_o,
    output logic                       sat_o
);

    localparam int LAT_W  = $clog2(MAX_LAT);
    localparam int FILL_W = LAT_W + 1;
    localparam int RUN_W  = $clog2(LOCK_LEN + 1);
    localparam int WIN_W  = $clog2(WIN + 1);
    localparam int WERR_W = $clog2(UNLOCK_ERR + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t              state, state_n;
    logic [MAX_LAT-1:0]  hist;
    logic [FILL_W-1:0]   fill_ct;
    logic [LAT_W-1:0]    cand;
    logic [RUN_W-1:0]    run_ct;
    logic [WIN_W-1:0]    win_ct;
    logic [WERR_W-1:0]   win_err;
    logic                cmp_vld, mm;
    logic                go_lock, go_search, win_rst;

    // Candidate is only trustworthy once that many bits have actually been pushed.
    assign cmp_vld = rx_valid_i && (fill_ct > {1'b0, cand});
    assign mm      = rx_bit_i ^ hist[cand];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SEARCH;
        else      state <= state_n;
    end

    always_comb begin
        state_n   = state;
        go_lock   = 1'b0;
        go_search = 1'b0;
        win_rst   = 1'b0;
        if (cmp_vld) begin
            unique case (state)
                SEARCH: begin
                    if (!mm && run_ct == RUN_W'(LOCK_LEN - 1)) begin
                        state_n = LOCKED;
                        go_lock = 1'b1;
                    end
                end
                LOCKED: begin
                    // Loss of lock wins over a coincident window restart.
                    if (win_err + WERR_W'(mm) >= WERR_W'(UNLOCK_ERR)) begin
                        state_n   = SEARCH;
                        go_search = 1'b1;
                    end else if (win_ct == WIN_W'(WIN - 1)) begin
                        win_rst = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist        <= '0;
            fill_ct     <= '0;
            cand        <= '0;
            run_ct      <= '0;
            win_ct      <= '0;
            win_err     <= '0;
            locked_o    <= 1'b0;
            latency_o   <= '0;
            lock_loss_o <= 1'b0;
        end else begin
            lock_loss_o <= go_search;
            if (tx_valid_i) begin
                hist <= {hist[MAX_LAT-2:0], tx_bit_i};
                if (fill_ct != FILL_W'(MAX_LAT)) fill_ct <= fill_ct + 1'b1;
            end
            if (cmp_vld && state == SEARCH) begin
                if (mm) begin
                    run_ct <= '0;
                    cand   <= cand + 1'b1;
                end else begin
                    run_ct <= run_ct + 1'b1;
                end
            end
            if (go_lock) begin
                locked_o  <= 1'b1;
                latency_o <= cand;
            end
            // cand is left alone on loss so the hunt restarts at the last good latency.
            if (go_search) begin
                locked_o <= 1'b0;
                run_ct   <= '0;
            end
            if (go_lock || go_search || win_rst) begin
                win_ct  <= '0;
                win_err <= '0;
            end else if (cmp_vld && state == LOCKED) begin
                win_ct  <= win_ct + 1'b1;
                win_err <= win_err + WERR_W'(mm);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_ct_o <= '0;
            err_ct_o <= '0;
            sat_o    <= 1'b0;
        end else if (clear_i) begin
            bit_ct_o <= '0;
            err_ct_o <= '0;
            sat_o    <= 1'b0;
        end else if (cmp_vld && state == LOCKED) begin
            if (bit_ct_o == '1) sat_o <= 1'b1;
            else                bit_ct_o <= bit_ct_o + 1'b1;
            if (mm) begin
                if (err_ct_o == '1) sat_o <= 1'b1;
                else                err_ct_o <= err_ct_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Randomized bench for viterbi_ber_checker: two instances (16-bit and 4-bit counters)
// share stimulus and are scored against a push-queue reference model.
module tb_viterbi_ber_checker;

    localparam int MAX_LAT    = 64;
    localparam int LOCK_LEN   = 32;
    localparam int WIN        = 64;
    localparam int UNLOCK_ERR = 8;

    logic clk = 1'b0, rst = 1'b0;
    logic tx_valid = 1'b0, tx_bit = 1'b0, rx_valid = 1'b0, rx_bit = 1'b0, clear = 1'b0;

    logic        locked_a, loss_a, sat_a;
    logic [5:0]  lat_a;
    logic [15:0] bit_a, err_a;
    logic        locked_b, loss_b, sat_b;
    logic [5:0]  lat_b;
    logic [3:0]  bit_b, err_b;

    int vectors = 0, fails = 0;
    int delay = 0;

    // Reference model: pushes[0] is the newest tx bit
    bit pushes[$];
    bit m_locked, m_loss;
    int m_cand, m_run, m_lat, m_win, m_werr;
    int m_bit[2], m_err[2];
    bit m_sat[2];
    int cmax[2] = '{65535, 15};

    viterbi_ber_checker #(.MAX_LAT(MAX_LAT), .LOCK_LEN(LOCK_LEN), .WIN(WIN),
                          .UNLOCK_ERR(UNLOCK_ERR), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .tx_valid_i(tx_valid), .tx_bit_i(tx_bit),
        .rx_valid_i(rx_valid), .rx_bit_i(rx_bit), .clear_i(clear),
        .locked_o(locked_a), .latency_o(lat_a), .bit_ct_o(bit_a), .err_ct_o(err_a),
        .lock_loss_o(loss_a), .sat_o(sat_a));

    viterbi_ber_checker #(.MAX_LAT(MAX_LAT), .LOCK_LEN(LOCK_LEN), .WIN(WIN),
                          .UNLOCK_ERR(UNLOCK_ERR), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .tx_valid_i(tx_valid), .tx_bit_i(tx_bit),
        .rx_valid_i(rx_valid), .rx_bit_i(rx_bit), .clear_i(clear),
        .locked_o(locked_b), .latency_o(lat_b), .bit_ct_o(bit_b), .err_ct_o(err_b),
        .lock_loss_o(loss_b), .sat_o(sat_b));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        pushes.delete();
        m_locked = 0; m_loss = 0; m_cand = 0; m_run = 0; m_lat = 0; m_win = 0; m_werr = 0;
        for (int k = 0; k < 2; k++) begin m_bit[k] = 0; m_err[k] = 0; m_sat[k] = 0; end
    endfunction

    function automatic void model_step(bit tv, bit tb_, bit rv, bit rb, bit cl);
        int fill       = (pushes.size() < MAX_LAT) ? pushes.size() : MAX_LAT;
        bit valid      = rv && (fill > m_cand);
        bit mm         = valid ? (rb ^ pushes[m_cand]) : 1'b0;
        bit was_locked = m_locked;
        m_loss = 0;
        if (valid && !was_locked) begin
            if (mm) begin
                m_run = 0;
                m_cand = (m_cand + 1) % MAX_LAT;
            end else begin
                m_run++;
                if (m_run == LOCK_LEN) begin
                    m_locked = 1; m_lat = m_cand; m_win = 0; m_werr = 0;
                end
            end
        end else if (valid) begin
            if (m_werr + mm >= UNLOCK_ERR) begin
                m_locked = 0; m_loss = 1; m_run = 0; m_win = 0; m_werr = 0;
            end else if (m_win + 1 == WIN) begin
                m_win = 0; m_werr = 0;
            end else begin
                m_win++; m_werr += mm;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (cl) begin
                m_bit[k] = 0; m_err[k] = 0; m_sat[k] = 0;
            end else if (valid && was_locked) begin
                if (m_bit[k] == cmax[k]) m_sat[k] = 1; else m_bit[k]++;
                if (mm) begin
                    if (m_err[k] == cmax[k]) m_sat[k] = 1; else m_err[k]++;
                end
            end
        end
        if (tv) pushes.push_front(tb_);
    endfunction

    // One clock: rx carries the tx bit pushed `delay` pushes before the newest one.
    task automatic step(input bit tv, input bit rv, input bit flip, input bit cl);
        bit tb_;
        tb_      = 1'($urandom);
        tx_valid = tv;
        tx_bit   = tb_;
        rx_valid = rv;
        clear    = cl;
        rx_bit   = (pushes.size() > delay) ? (pushes[delay] ^ flip) : 1'($urandom);
        model_step(tv, tb_, rv, rx_bit, cl);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tx_valid = 1'($urandom); tx_bit = 1'($urandom);
            rx_valid = 1'($urandom); rx_bit = 1'($urandom); clear = 1'($urandom);
            @(posedge clk); #1;
            vectors++;
            if ({locked_a, loss_a, sat_a, lat_a, bit_a, err_a,
                 locked_b, loss_b, sat_b, lat_b, bit_b, err_b} !== 58'd0) begin
                fails++;
                $display("FAIL reset_hold: outputs=%h required 0",
                         {locked_a, loss_a, sat_a, lat_a, bit_a, err_a,
                          locked_b, loss_b, sat_b, lat_b, bit_b, err_b});
            end
        end
        tx_valid = 0; rx_valid = 0; clear = 0;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_clean_lock();
        int n = 0;
        delay = 10;
        while (!locked_a && n < 300) begin step(1, 1, 0, 0); n++; end
        vectors++;
        if (locked_a !== 1'b1 || lat_a !== 6'd10 || locked_b !== 1'b1 || lat_b !== 6'd10) begin
            fails++;
            $display("FAIL clean_lock: locked=%b/%b lat=%0d/%0d after %0d cycles, required 1 lat 10",
                     locked_a, locked_b, lat_a, lat_b, n);
        end
        vectors++;
        if (m_locked !== 1'b1 || m_lat != 10) begin
            fails++;
            $display("FAIL clean_lock_timing: model locked=%b lat=%0d when DUT locked, required 1 / 10",
                     m_locked, m_lat);
        end
        for (int i = 0; i < 1000; i++) step(1, 1, 0, 0);
        vectors++;
        if (bit_a !== 16'd1000 || err_a !== 16'd0 || sat_a !== 1'b0) begin
            fails++;
            $display("FAIL clean_count: bit=%0d err=%0d sat=%b required 1000 0 0", bit_a, err_a, sat_a);
        end
        vectors++;
        if (bit_b !== 4'd15 || err_b !== 4'd0 || sat_b !== 1'b1) begin
            fails++;
            $display("FAIL clean_count_w4: bit=%0d err=%0d sat=%b required 15 0 1", bit_b, err_b, sat_b);
        end
    endtask

    task automatic test_sparse_errors();
        step(1, 1, 0, 1);
        vectors++;
        if (bit_a !== 16'd0 || err_a !== 16'd0 || sat_b !== 1'b0 || locked_a !== 1'b1) begin
            fails++;
            $display("FAIL clear_before_sparse: bit=%0d err=%0d sat4=%b locked=%b required 0 0 0 1",
                     bit_a, err_a, sat_b, locked_a);
        end
        for (int w = 0; w < 10; w++) begin
            int p0, p1, p2;
            p0 = $urandom_range(0, 63);
            do p1 = $urandom_range(0, 63); while (p1 == p0);
            do p2 = $urandom_range(0, 63); while (p2 == p0 || p2 == p1);
            for (int i = 0; i < 64; i++) begin
                step(1, 1, (i == p0 || i == p1 || i == p2), 0);
                vectors++;
                if (locked_a !== 1'b1 || loss_a !== 1'b0) begin
                    fails++;
                    $display("FAIL sparse_hold: locked=%b loss=%b required 1 0", locked_a, loss_a);
                end
            end
        end
        vectors++;
        if (bit_a !== 16'd640 || err_a !== 16'd30) begin
            fails++;
            $display("FAIL sparse_count: bit=%0d err=%0d required 640 30", bit_a, err_a);
        end
    endtask

    task automatic test_lock_loss();
        int n = 0;
        while (m_win != 0 && n < 64) begin step(1, 1, 0, 0); n++; end
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 1, 0);
            if (i < 7) begin
                vectors++;
                if (locked_a !== 1'b1 || loss_a !== 1'b0) begin
                    fails++;
                    $display("FAIL early_loss: err#%0d locked=%b loss=%b required 1 0", i + 1, locked_a, loss_a);
                end
            end
        end
        vectors++;
        if (loss_a !== 1'b1 || locked_a !== 1'b0 || lat_a !== 6'd10 || loss_b !== 1'b1) begin
            fails++;
            $display("FAIL lock_loss: loss=%b locked=%b lat=%0d required 1 0 10", loss_a, locked_a, lat_a);
        end
        step(1, 1, 0, 0);
        vectors++;
        if (loss_a !== 1'b0 || locked_a !== 1'b0) begin
            fails++;
            $display("FAIL loss_pulse: loss=%b locked=%b required 0 0", loss_a, locked_a);
        end
        n = 0;
        while (!locked_a && n < 200) begin step(1, 1, 0, 0); n++; end
        vectors++;
        if (locked_a !== 1'b1 || lat_a !== 6'd10 || n != LOCK_LEN - 1) begin
            fails++;
            $display("FAIL relock: locked=%b lat=%0d cycles=%0d required 1 10 %0d",
                     locked_a, lat_a, n, LOCK_LEN - 1);
        end
    endtask

    task automatic test_wrap();
        int target[2] = '{63, 2};
        for (int t = 0; t < 2; t++) begin
            int n = 0;
            bit saw_loss = 0;
            delay = target[t];
            while (!(saw_loss && locked_a) && n < 3000) begin
                step(1, 1, 0, 0);
                if (loss_a) saw_loss = 1;
                n++;
            end
            vectors++;
            if (!saw_loss || locked_a !== 1'b1 || lat_a !== 6'(target[t]) || lat_a !== 6'(m_lat)) begin
                fails++;
                $display("FAIL wrap_relock: loss_seen=%b locked=%b lat=%0d required 1 1 %0d",
                         saw_loss, locked_a, lat_a, target[t]);
            end
        end
    endtask

    task automatic test_clear_sat();
        step(1, 1, 0, 1);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0);
        vectors++;
        if (bit_b !== 4'd15 || sat_b !== 1'b1 || bit_a !== 16'd20 || sat_a !== 1'b0) begin
            fails++;
            $display("FAIL saturation: bit4=%0d sat4=%b bit16=%0d sat16=%b required 15 1 20 0",
                     bit_b, sat_b, bit_a, sat_a);
        end
        step(1, 1, 0, 1);
        vectors++;
        if (bit_b !== 4'd0 || err_b !== 4'd0 || sat_b !== 1'b0 || bit_a !== 16'd0 || locked_b !== 1'b1) begin
            fails++;
            $display("FAIL clear: bit4=%0d err4=%0d sat4=%b bit16=%0d locked=%b required 0 0 0 0 1",
                     bit_b, err_b, sat_b, bit_a, locked_b);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0));
            vectors++;
            if (locked_a !== m_locked || loss_a !== m_loss || lat_a !== 6'(m_lat) ||
                bit_a !== 16'(m_bit[0]) || err_a !== 16'(m_err[0]) || sat_a !== m_sat[0] ||
                bit_b !== 4'(m_bit[1]) || err_b !== 4'(m_err[1]) || sat_b !== m_sat[1]) begin
                fails++;
                $display("FAIL random_strobes: cyc %0d dut l=%b x=%b lat=%0d b=%0d e=%0d s=%b b4=%0d e4=%0d s4=%b model l=%b x=%b lat=%0d b=%0d e=%0d s=%b b4=%0d e4=%0d s4=%b",
                         i, locked_a, loss_a, lat_a, bit_a, err_a, sat_a, bit_b, err_b, sat_b,
                         m_locked, m_loss, m_lat, m_bit[0], m_err[0], m_sat[0], m_bit[1], m_err[1], m_sat[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b0;
        #1;
        vectors++;
        if ({locked_a, loss_a, sat_a, lat_a, bit_a, err_a} !== 41'd0) begin
            fails++;
            $display("FAIL reset_mid: outputs=%h required 0", {locked_a, loss_a, sat_a, lat_a, bit_a, err_a});
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        delay = 5;
        for (int i = 0; i < 60; i++) step(1, 1, 0, 0);
        vectors++;
        if (locked_a !== m_locked || lat_a !== 6'(m_lat) || bit_a !== 16'(m_bit[0])) begin
            fails++;
            $display("FAIL reset_mid_relock: locked=%b lat=%0d bit=%0d required %b %0d %0d",
                     locked_a, lat_a, bit_a, m_locked, m_lat, m_bit[0]);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_lock();
        test_sparse_errors();
        test_lock_loss();
        test_wrap();
        test_clear_sat();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
